// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: EX-to-MEM pipeline bus, MEM fields and fetch redirect handshake
interface ex_mem_stage_if #(parameter int DATA_LENGTH = 32);
    logic                   ex_valid;
    logic                   ex_ready;
    logic [DATA_LENGTH-1:0] alu_out;
    logic [DATA_LENGTH-1:0] target_pc;
    logic [DATA_LENGTH-1:0] pc_ex;
    logic [DATA_LENGTH-1:0] rs2_data_ex;
    logic                   ge;
    logic                   eq;
    logic                   branch_ex;
    logic                   jal;
    logic                   jalr;
    logic [2:0]             br_type;
    logic [4:0]             rd_ex;
    logic                   reg_write_ex;
    logic                   mem_read_ex;
    logic                   mem_write_ex;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [DATA_LENGTH-1:0] alu_out_mem;
    logic [DATA_LENGTH-1:0] rs2_data_mem;
    logic [4:0]             rd_mem;
    logic                   reg_write_mem;
    logic                   mem_read_mem;
    logic                   mem_write_mem;
    logic                   misalign_mem;
    logic                   redirect_valid;
    logic [DATA_LENGTH-1:0] redirect_pc;
    logic                   redirect_ack;
    logic                   flush;

    modport slave (
        input  ex_valid, alu_out, target_pc, pc_ex, rs2_data_ex, ge, eq, branch_ex, jal, jalr,
               br_type, rd_ex, reg_write_ex, mem_read_ex, mem_write_ex, mem_ready, redirect_ack, flush,
        output ex_ready, mem_valid, alu_out_mem, rs2_data_mem, rd_mem, reg_write_mem, mem_read_mem,
               mem_write_mem, misalign_mem, redirect_valid, redirect_pc
    );

    modport master (
        output ex_valid, alu_out, target_pc, pc_ex, rs2_data_ex, ge, eq, branch_ex, jal, jalr,
               br_type, rd_ex, reg_write_ex, mem_read_ex, mem_write_ex, mem_ready, redirect_ack, flush,
        input  ex_ready, mem_valid, alu_out_mem, rs2_data_mem, rd_mem, reg_write_mem, mem_read_mem,
               mem_write_mem, misalign_mem, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch resolution and fetch redirect handshake
module ex_mem_stage #(
    parameter int DATA_LENGTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    ex_mem_stage_if.slave  bus
);
    typedef enum logic {IDLE, REDIR_WAIT} state_t;

    state_t                 state, state_next;
    logic                   br_taken, taken, misaligned, accept, load_redir;
    logic [DATA_LENGTH-1:0] target;
    logic                   unused_pc;

    assign unused_pc  = ^bus.pc_ex;
    assign br_taken   = (bus.br_type == 3'b000) ? bus.eq :
                        (bus.br_type == 3'b001) ? !bus.eq :
                        (bus.br_type[2] && !bus.br_type[0]) ? !bus.ge :
                        (bus.br_type[2] && bus.br_type[0]) ? bus.ge : 1'b0;
    assign taken      = bus.jal || bus.jalr || (bus.branch_ex && br_taken);
    assign target     = {bus.target_pc[DATA_LENGTH-1:1], bus.target_pc[0] & ~bus.jalr};
    assign misaligned = taken && target[1];

    assign bus.ex_ready       = (state == IDLE) && (!bus.mem_valid || bus.mem_ready) && !bus.flush;
    assign accept             = bus.ex_valid && bus.ex_ready;
    assign bus.redirect_valid = (state == REDIR_WAIT);

    // flush wins over both a new redirect and an ack arriving in the same cycle
    always_comb begin
        state_next = state;
        load_redir = 1'b0;
        if (bus.flush) begin
            state_next = IDLE;
        end else if (state == IDLE) begin
            load_redir = accept && taken && !misaligned;
            state_next = load_redir ? REDIR_WAIT : IDLE;
        end else if (bus.redirect_ack) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.redirect_pc <= '0;
        end else begin
            state           <= state_next;
            bus.redirect_pc <= load_redir ? target : bus.redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_valid     <= 1'b0;
            bus.alu_out_mem   <= '0;
            bus.rs2_data_mem  <= '0;
            bus.rd_mem        <= '0;
            bus.reg_write_mem <= 1'b0;
            bus.mem_read_mem  <= 1'b0;
            bus.mem_write_mem <= 1'b0;
            bus.misalign_mem  <= 1'b0;
        end else if (bus.flush) begin
            bus.mem_valid <= 1'b0;
        end else if (accept) begin
            bus.mem_valid     <= 1'b1;
            bus.alu_out_mem   <= bus.alu_out;
            bus.rs2_data_mem  <= bus.rs2_data_ex;
            bus.rd_mem        <= bus.rd_ex;
            bus.reg_write_mem <= bus.reg_write_ex && !misaligned;
            bus.mem_read_mem  <= bus.mem_read_ex;
            bus.mem_write_mem <= bus.mem_write_ex;
            bus.misalign_mem  <= misaligned;
        end else if (bus.mem_ready) begin
            bus.mem_valid <= 1'b0;
        end
    end
endmodule
